// File: rtl/mem_burst_bridge.sv
// mem_burst_bridge: fetches one 8-beat block from a fixed-latency backing memory and streams it out in beat order,
// with read issue credit-gated by a beat FIFO so consumer backpressure never loses data.
module mem_burst_bridge #(
  parameter int MEM_IF_ADDR = 16,
  parameter int MEM_IF_DATA = 40,
  parameter int BEATS       = 8,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                      clk,
  input  logic                                      arst_n,
  input  logic                                      i_halt,
  input  logic [MEM_IF_ADDR-1:0]                    i_req_addr,
  input  logic                                      i_req_valid,
  output logic                                      o_req_ready,
  output logic [MEM_IF_ADDR-5+$clog2(BEATS):0]      o_bm_addr,
  output logic                                      o_bm_rd_en,
  input  logic [MEM_IF_DATA-1:0]                    i_bm_rdata,
  output logic [MEM_IF_DATA-1:0]                    o_data,
  output logic                                      o_data_valid,
  output logic                                      o_data_last,
  input  logic                                      i_data_ready,
  output logic                                      o_busy
);
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state, state_nx;
  logic [MEM_IF_ADDR-5:0] block;
  logic [BW-1:0] issue_cnt, wr_cnt;
  logic [CW-1:0] credits, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [RD_LATENCY-1:0] pipe;
  logic [MEM_IF_DATA-1:0] fifo_d [FIFO_DEPTH];
  logic [BW-1:0] fifo_i [FIFO_DEPTH];
  logic issue, push, pop, head_last, unused_ok;
  assign unused_ok    = ^i_req_addr[3:0];
  assign issue        = state == ISSUE && !i_halt && credits != '0;
  assign push         = pipe[RD_LATENCY-1];
  assign head_last    = fifo_i[rd_ptr] == BW'(BEATS - 1);
  assign o_req_ready  = state == IDLE;
  assign o_busy       = state != IDLE;
  assign o_bm_rd_en   = issue;
  assign o_bm_addr    = {block, issue_cnt};
  assign o_data       = fifo_d[rd_ptr];
  assign o_data_valid = count != '0 && !i_halt;
  assign o_data_last  = o_data_valid && head_last;
  assign pop          = o_data_valid && i_data_ready;
  always_comb
    state_nx = state == IDLE  ? (i_req_valid ? ISSUE : IDLE) :
               state == ISSUE ? (issue && issue_cnt == BW'(BEATS - 1) ? DRAIN : ISSUE) :
               (pop && head_last ? IDLE : DRAIN);
  // Beat index travels with the data because issue and pop run at different rates.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state     <= IDLE;
      block     <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      credits   <= CW'(FIFO_DEPTH);
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pipe      <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_d[k] <= '0;
        fifo_i[k] <= '0;
      end
    end else begin
      state   <= state_nx;
      pipe    <= (pipe << 1) | RD_LATENCY'(issue);
      credits <= credits - CW'(issue) + CW'(pop);
      count   <= count + CW'(push) - CW'(pop);
      if (state == IDLE && i_req_valid) block <= i_req_addr[MEM_IF_ADDR-1:4];
      if (issue) issue_cnt <= issue_cnt + 1'b1;
      if (push) begin
        fifo_d[wr_ptr] <= i_bm_rdata;
        fifo_i[wr_ptr] <= wr_cnt;
        wr_cnt         <= wr_cnt + 1'b1;
        wr_ptr         <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
    end
endmodule

// File: doc/mem_burst_bridge.md
Name: mem_burst_bridge

Overview:
Memory-side neighbour of the cache miss handler. Accepts one block-fill request (16-bit block address), reads the 8 x 40-bit beats of that 320-bit block from a fixed-latency backing memory, and returns them in ascending beat order over a valid/ready beat interface into the miss handler's memory-data inputs. Read issue is credit-gated through an internal beat FIFO, so backpressure never drops data.

Parameters:
MEM_IF_ADDR, 16, request address width; bits [3:0] are the block offset and are ignored.
MEM_IF_DATA, 40, beat width.
BEATS, 8, beats per block; beat index width is 3.
RD_LATENCY, 2, backing-memory read latency in cycles; legal range 1..4.
FIFO_DEPTH, 4, beat FIFO entries; must be at least 2. Full throughput requires at least RD_LATENCY+2.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_halt  in  1  freeze issue and output
i_req_addr  in  16  block request address
i_req_valid  in  1  request valid
o_req_ready  out  1  high only in IDLE
o_bm_addr  out  15  backing address: {i_req_addr[15:4], beat[2:0]}
o_bm_rd_en  out  1  backing read strobe
i_bm_rdata  in  40  backing read data, valid RD_LATENCY cycles after rd_en
o_data  out  40  beat data, i.e. the FIFO head
o_data_valid  out  1  beat valid
o_data_last  out  1  high with beat 7
i_data_ready  in  1  consumer ready
o_busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_req_ready=1. FIFO is emptied, credits = FIFO_DEPTH, issue counter = 0, latency pipe is cleared, state = IDLE.
- Reset asserted mid-burst aborts the burst. Reads already in flight are discarded, because the latency pipe is cleared.
- Request acceptance: at a clock edge where i_req_valid and o_req_ready are both high, capture i_req_addr[15:4]. Next state is ISSUE. Requests outside IDLE are ignored.
- FSM states:
  - IDLE: waits for a request.
  - ISSUE: leaves for DRAIN on the edge that issues beat 7.
  - DRAIN: leaves for IDLE on the edge that pops beat 7.
  - When IDLE is re-entered, o_req_ready=1 in the following cycle.
- Issue rule (ISSUE state only): o_bm_rd_en = ~i_halt & (credits != 0).
  - o_bm_addr = {block, issue_cnt}.
  - On each issue: credits decrements and issue_cnt increments, wrapping 7 -> 0.
- Latency pipe: a RD_LATENCY-deep shift register of rd_en. When its output is 1, i_bm_rdata is written into the FIFO on that edge. The entry is visible on o_data/o_data_valid in the next cycle.
- Output:
  - o_data_valid = FIFO non-empty & ~i_halt.
  - Pop occurs when o_data_valid & i_data_ready.
  - o_data_last = o_data_valid & (head beat index == 7); the beat index is stored alongside the data.
- Credit return: each pop increments credits, usable from the next cycle. A simultaneous issue and pop leaves credits unchanged.
- Credits guarantee the FIFO never overflows. Push and pop in the same cycle on a full FIFO is legal.
- i_halt:
  - Blocks issue and pop.
  - Forces o_data_valid=0.
  - Does not stop the latency pipe; data still in flight is written, which credits guarantee has room.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH. count = 0..FIFO_DEPTH.
- Timing with defaults and no stall:
  - Request accepted in cycle 0.
  - rd_en in cycles 1-8.
  - o_data_valid for beats 0-7 in cycles 4-11.
  - o_req_ready=1 in cycle 12.

Test Plan:
- Reset, then a request with addr 0xABC5 into memory holding word(a) = {25'h0, a}: rd_en addresses 0x55E0-0x55E7 in cycles 1-8; beats 0x55E0..0x55E7 valid in cycles 4-11; last only in cycle 11; ready in cycle 12.
- i_data_ready held low from cycle 3 to cycle 20: exactly 4 reads issue (cycles 1-4) and the FIFO fills to 4. After release, 8 beats arrive in order with no loss or duplication.
- i_halt pulsed for 3 cycles mid-burst: o_data_valid=0 and rd_en=0 during the halt. In-flight beats are absorbed. Total of 8 ordered beats.
- i_req_valid held high during a burst with a different address: no second capture until IDLE. The second burst follows immediately, with o_bm_addr using the new block.
- arst_n asserted in cycle 6: all outputs go to reset values immediately and o_req_ready=1. A new request completes cleanly with no stale beats.
- RD_LATENCY=3, FIFO_DEPTH=5: first beat in cycle 5, and 8 contiguous beats.
